// File: rtl/fetch_pkg.sv
// Shared constants, FSM encoding and buffer entry type for the instruction fetch controller.
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t StIdle  = 2'd0;
  localparam fetch_state_t StFetch = 2'd1;
  localparam fetch_state_t StDrop  = 2'd2;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {pc, data} entries; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign rdata = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single outstanding memory request feeding a small buffer.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        stat_instruction_fetched
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic            stat_q;
  logic            ack, enq, deq, can_issue;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   occ_next;
  fetch_entry_t    push_entry, head;

  assign ack = (state_q != StIdle) && imem_ack;
  assign enq = (state_q == StFetch) && ack && !redirect_valid;
  assign deq = !fifo_empty && inst_ready && !redirect_valid;

  assign occ_next  = redirect_valid ? '0 :
                     ({1'b0, fifo_count} + (CntW+1)'(enq) - (CntW+1)'(deq));
  assign can_issue = fetch_enable && (occ_next < (CntW+1)'(FIFO_DEPTH));

  assign push_entry = '{pc: pc_q, data: imem_rdata};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'h3;
    end else if (enq) begin
      pc_d = pc_q + PC_INCR;
    end
    unique case (state_q)
      StIdle: begin
        if (can_issue) begin
          state_d = StFetch;
          addr_d  = pc_d;
        end
      end
      StFetch, StDrop: begin
        if (ack) begin
          if (can_issue) begin
            state_d = StFetch;
            addr_d  = pc_d;
          end else begin
            state_d = StIdle;
          end
        end else if (redirect_valid) begin
          // Address stays put until the ack; only the response gets thrown away.
          state_d = StDrop;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      stat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      stat_q  <= enq;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CntW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enq),
    .pop   (deq),
    .flush (redirect_valid),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue is gated on occupancy, so a response can never land in a full buffer.
  assert property (@(posedge clk) disable iff (reset) !(enq && fifo_full));

  assign imem_req                 = (state_q != StIdle);
  assign imem_addr                = addr_q;
  assign inst_valid               = !fifo_empty;
  assign inst_data                = head.data;
  assign inst_pc                  = head.pc;
  assign stat_instruction_fetched = stat_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_fetch_ctrl;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ack = 1'b0;
  logic        inst_ready = 1'b0;
  logic [31:0] salt = 32'h1234_5678;

  logic        imem_req, inst_valid, stat;
  logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc;
  logic        w_req, w_valid, w_stat;
  logic [31:0] w_addr, w_rdata, w_data, w_pc;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  // Memory returns a value derived from the address so misrouted data is visible.
  assign imem_rdata = imem_addr ^ salt;
  assign w_rdata    = w_addr ^ salt;

  fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk                      (clk),
    .reset                    (reset),
    .fetch_enable             (fetch_enable),
    .redirect_valid           (redirect_valid),
    .redirect_pc              (redirect_pc),
    .imem_req                 (imem_req),
    .imem_addr                (imem_addr),
    .imem_ack                 (imem_ack),
    .imem_rdata               (imem_rdata),
    .inst_valid               (inst_valid),
    .inst_ready               (inst_ready),
    .inst_data                (inst_data),
    .inst_pc                  (inst_pc),
    .stat_instruction_fetched (stat)
  );

  fetch_ctrl #(
    .RESET_PC   (32'hFFFF_FFFC),
    .FIFO_DEPTH (4)
  ) u_wrap (
    .clk                      (clk),
    .reset                    (reset),
    .fetch_enable             (fetch_enable),
    .redirect_valid           (redirect_valid),
    .redirect_pc              (redirect_pc),
    .imem_req                 (w_req),
    .imem_addr                (w_addr),
    .imem_ack                 (imem_ack),
    .imem_rdata               (w_rdata),
    .inst_valid               (w_valid),
    .inst_ready               (inst_ready),
    .inst_data                (w_data),
    .inst_pc                  (w_pc),
    .stat_instruction_fetched (w_stat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of buffered instructions plus one pending-request record.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          m_pend, m_drop, m_stat;
  bit          m_ack, m_enq, m_deq;
  logic [31:0] m_fpc, m_addr;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_pend = 1'b0;
      m_drop = 1'b0;
      m_stat = 1'b0;
      m_fpc  = 32'h0;
      m_addr = 32'h0;
    end else begin
      m_ack = m_pend && imem_ack;
      m_enq = m_ack && !m_drop && !redirect_valid;
      m_deq = (mq.size() > 0) && inst_ready && !redirect_valid;
      if (redirect_valid) begin
        mq.delete();
        m_fpc = redirect_pc & ~32'h3;
        if (m_pend && !m_ack) m_drop = 1'b1;
      end else begin
        if (m_deq) void'(mq.pop_front());
        if (m_enq) begin
          mq.push_back('{pc: m_fpc, data: m_addr ^ salt});
          m_fpc = m_fpc + 32'd4;
        end
      end
      m_stat = m_enq;
      if (m_ack) m_pend = 1'b0;
      if (!m_pend && fetch_enable && (mq.size() < DEPTH)) begin
        m_pend = 1'b1;
        m_drop = 1'b0;
        m_addr = m_fpc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model imem_req", {31'd0, imem_req}, {31'd0, m_pend});
      if (m_pend) chk("model imem_addr", imem_addr, m_addr);
      chk("model inst_valid", {31'd0, inst_valid}, {31'd0, mq.size() > 0});
      chk("model stat", {31'd0, stat}, {31'd0, m_stat});
      if (mq.size() > 0) begin
        chk("model inst_pc", inst_pc, mq[0].pc);
        chk("model inst_data", inst_data, mq[0].data);
      end
    end
  end

  task automatic do_reset();
    reset          = 1'b1;
    fetch_enable   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ack       = 1'b0;
    inst_ready     = 1'b0;
    salt           = 32'h1234_5678;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset values, then zero-wait streaming (also exercises the wrapping instance).
    do_reset();
    chk("rst imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst stat", {31'd0, stat}, 32'd0);
    chk("rst inst_data", inst_data, 32'd0);
    chk("rst inst_pc", inst_pc, 32'd0);
    reset = 1'b0; fetch_enable = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    chk("stream addr0", imem_addr, 32'h0);
    chk("wrap req0", {31'd0, w_req}, 32'd1);
    chk("wrap addr0", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("stream addr1", imem_addr, 32'h4);
    chk("stream pc1", inst_pc, 32'h0);
    chk("stream data1", inst_data, 32'h1234_5678);
    chk("stream stat1", {31'd0, stat}, 32'd1);
    chk("wrap addr1", w_addr, 32'h0);
    chk("wrap valid1", {31'd0, w_valid}, 32'd1);
    chk("wrap stat1", {31'd0, w_stat}, 32'd1);
    chk("wrap pc1", w_pc, 32'hFFFF_FFFC);
    chk("wrap data1", w_data, 32'hFFFF_FFFC ^ 32'h1234_5678);
    @(negedge clk);
    chk("stream addr2", imem_addr, 32'h8);
    chk("stream pc2", inst_pc, 32'h4);

    // Backpressure: two entries buffered, request drops, resumes at 0x8.
    do_reset();
    reset = 1'b0; fetch_enable = 1'b1; imem_ack = 1'b1; inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("full req", {31'd0, imem_req}, 32'd0);
    chk("full pc", inst_pc, 32'h0);
    @(negedge clk);
    chk("full req held", {31'd0, imem_req}, 32'd0);
    inst_ready = 1'b1;
    @(negedge clk);
    chk("resume req", {31'd0, imem_req}, 32'd1);
    chk("resume addr", imem_addr, 32'h8);
    chk("resume pc", inst_pc, 32'h4);

    // Redirect while the request at 0x8 waits on a 3-cycle ack.
    do_reset();
    reset = 1'b0; fetch_enable = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("drop addr8", imem_addr, 32'h8);
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    chk("drop addr held", imem_addr, 32'h8);
    chk("drop flushed", {31'd0, inst_valid}, 32'd0);
    redirect_valid = 1'b0;
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    chk("drop new addr", imem_addr, 32'h100);
    chk("drop no stat", {31'd0, stat}, 32'd0);
    chk("drop no valid", {31'd0, inst_valid}, 32'd0);

    // Redirect coincident with an ack, one entry buffered.
    do_reset();
    reset = 1'b0; fetch_enable = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("coinc one entry", {31'd0, inst_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    chk("coinc empty", {31'd0, inst_valid}, 32'd0);
    chk("coinc addr", imem_addr, 32'h200);
    chk("coinc no stat", {31'd0, stat}, 32'd0);
    redirect_valid = 1'b0;

    // Reset during a pending request, stray ack one cycle later.
    do_reset();
    reset = 1'b0; fetch_enable = 1'b1; imem_ack = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    chk("rstmid req", {31'd0, imem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid idle", {31'd0, imem_req}, 32'd0);
    reset = 1'b0; imem_ack = 1'b1;
    @(negedge clk);
    chk("rstmid restart", imem_addr, 32'h0);
    chk("rstmid no valid", {31'd0, inst_valid}, 32'd0);
    chk("rstmid no stat", {31'd0, stat}, 32'd0);
    @(negedge clk);
    chk("rstmid first pc", inst_pc, 32'h0);

    // Randomized traffic; the first stretch uses zero-wait acks to keep the buffer busy.
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 299) == 0);
      fetch_enable   = ($urandom_range(0, 9) < 8);
      inst_ready     = ($urandom_range(0, 9) < 6);
      imem_ack       = (i < 1000) ? 1'b1 : 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom();
      salt           = $urandom();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
